rr_arbiter4: RTL and testbench

RR_ARBITER4 -- requirements
Module: rr_arbiter4

---
 rtl/rr_arbiter4.sv | 133 +++++++++++++
 tb/tb_rr_arbiter4.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter4.sv
// rr_arbiter4: four-way round-robin arbiter with a hold limit.
// One grant at a time; the owner keeps it until it signals done, drops its
// request, or exceeds MAX_HOLD cycles. Every release is followed by at least
// one idle cycle, and the search pointer moves past the last owner.
module rr_arbiter4 #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       gnt_valid,
  output logic       timeout
);

  localparam int unsigned HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic [3:0]    gnt_q, gnt_d;
  logic [1:0]    gnt_id_q, gnt_id_d;
  logic          gnt_valid_q, gnt_valid_d;
  logic          timeout_q, timeout_d;

  logic [3:0]    req_rot;
  logic [1:0]    enc;
  logic [1:0]    winner;
  logic          any_req;
  logic          at_limit;
  logic          owner_req;
  logic          release_now;

  // Cyclic search from ptr: rotate so ptr lands at bit 0, take the lowest
  // set bit, then shift the index back by ptr (2-bit add wraps mod 4).
  always_comb begin
    case (ptr_q)
      2'd0:    req_rot = req;
      2'd1:    req_rot = {req[0],   req[3:1]};
      2'd2:    req_rot = {req[1:0], req[3:2]};
      default: req_rot = {req[2:0], req[3]};
    endcase
    enc = 2'd0;
    if (req_rot[0])      enc = 2'd0;
    else if (req_rot[1]) enc = 2'd1;
    else if (req_rot[2]) enc = 2'd2;
    else if (req_rot[3]) enc = 2'd3;
    any_req = |req;
    winner  = enc + ptr_q;
  end

  // Release conditions for the current owner.
  always_comb begin
    at_limit    = (hold_cnt_q == HOLD_LAST);
    owner_req   = req[gnt_id_q];
    release_now = done || !owner_req || at_limit;
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    hold_cnt_d  = hold_cnt_q;
    gnt_d       = gnt_q;
    gnt_id_d    = gnt_id_q;
    gnt_valid_d = gnt_valid_q;
    timeout_d   = 1'b0;
    case (state_q)
      IDLE: begin
        gnt_d       = '0;
        gnt_valid_d = 1'b0;
        if (any_req) begin
          state_d     = BUSY;
          gnt_d       = 4'b0001 << winner;
          gnt_id_d    = winner;
          gnt_valid_d = 1'b1;
          hold_cnt_d  = '0;
        end
      end
      BUSY: begin
        hold_cnt_d = hold_cnt_q + HW'(1);
        if (release_now) begin
          state_d     = IDLE;
          gnt_d       = '0;
          gnt_valid_d = 1'b0;
          ptr_d       = gnt_id_q + 2'd1;
          // Only a pure hold-limit revocation is reported as a timeout.
          timeout_d   = at_limit && !done && owner_req;
        end
      end
      default: begin
        state_d     = IDLE;
        gnt_d       = '0;
        gnt_valid_d = 1'b0;
      end
    endcase
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      hold_cnt_q  <= '0;
      gnt_q       <= '0;
      gnt_id_q    <= '0;
      gnt_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      hold_cnt_q  <= hold_cnt_d;
      gnt_q       <= gnt_d;
      gnt_id_q    <= gnt_id_d;
      gnt_valid_q <= gnt_valid_d;
      timeout_q   <= timeout_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_id    = gnt_id_q;
  assign gnt_valid = gnt_valid_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed bench for rr_arbiter4: a vector table for rotation, skipping and
// busy-time isolation, plus hand sequences for glitches, withdrawal, the
// hold limit and asynchronous reset.
module tb_rr_arbiter4;

  localparam int unsigned MAXH = 8;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       gnt_valid;
  logic       timeout;

  int n_cmp = 0;
  int n_err = 0;

  rr_arbiter4 #(.MAX_HOLD(MAXH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] id;
    logic       valid;
    logic       to;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [7:0] obs();
    return {gnt, gnt_id, gnt_valid, timeout};
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;

    // Rotation 0,1,2,3,0 with a gap after each release.
    vecs.push_back(vec_t'{4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0});
    vecs.push_back(vec_t'{4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0});
    vecs.push_back(vec_t'{4'b1111, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0});
    vecs.push_back(vec_t'{4'b1111, 1'b1, 4'b0000, 2'd1, 1'b0, 1'b0});
    vecs.push_back(vec_t'{4'b1111, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0});
    vecs.push_back(vec_t'{4'b1111, 1'b1, 4'b0000, 2'd2, 1'b0, 1'b0});
    vecs.push_back(vec_t'{4'b1111, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0});
    vecs.push_back(vec_t'{4'b1111, 1'b1, 4'b0000, 2'd3, 1'b0, 1'b0});
    vecs.push_back(vec_t'{4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0});
    vecs.push_back(vec_t'{4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0});
    // Grant id 1 so ptr=2, then req=0011 must skip to id 0, leaving ptr=1.
    vecs.push_back(vec_t'{4'b1111, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0});
    vecs.push_back(vec_t'{4'b1111, 1'b1, 4'b0000, 2'd1, 1'b0, 1'b0});
    vecs.push_back(vec_t'{4'b0011, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0});
    vecs.push_back(vec_t'{4'b0011, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0});
    vecs.push_back(vec_t'{4'b0011, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0});
    vecs.push_back(vec_t'{4'b0011, 1'b1, 4'b0000, 2'd1, 1'b0, 1'b0});
    // Other requesters toggling during BUSY leave the grant alone.
    vecs.push_back(vec_t'{4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0});
    vecs.push_back(vec_t'{4'b1101, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0});
    vecs.push_back(vec_t'{4'b0111, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0});
    vecs.push_back(vec_t'{4'b0000, 1'b0, 4'b0000, 2'd2, 1'b0, 1'b0});
    vecs.push_back(vec_t'{4'b0000, 1'b0, 4'b0000, 2'd2, 1'b0, 1'b0});
    vecs.push_back(vec_t'{4'b1001, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0});
    vecs.push_back(vec_t'{4'b1001, 1'b1, 4'b0000, 2'd3, 1'b0, 1'b0});
    // done in IDLE is ignored; ptr wrapped to 0.
    vecs.push_back(vec_t'{4'b0000, 1'b1, 4'b0000, 2'd3, 1'b0, 1'b0});
    vecs.push_back(vec_t'{4'b0011, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0});
    vecs.push_back(vec_t'{4'b0011, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0});

    // Reset: outputs clear asynchronously and stay clear until the first edge.
    rst_n = 1'b1;
    req   = 4'b0000;
    done  = 1'b0;
    #2 rst_n = 1'b0;
    #1 check("reset_async", obs(), 8'h00);
    req = 4'b1111;
    step();
    check("reset_held", obs(), 8'h00);
    #3 rst_n = 1'b1;
    #1 check("reset_release_before_edge", obs(), 8'h00);
    #1;

    foreach (vecs[i]) begin
      req  = vecs[i].req;
      done = vecs[i].done;
      step();
      check($sformatf("vec%0d", i), obs(),
            {vecs[i].gnt, vecs[i].id, vecs[i].valid, vecs[i].to});
    end
    // State now: IDLE, ptr=1, gnt_id=0.

    // A request pulse wholly between edges in IDLE is never granted.
    req  = 4'b0000;
    done = 1'b0;
    #2 req = 4'b0100;
    #2 req = 4'b0000;
    step();
    check("glitch_no_grant", obs(), {4'b0000, 2'd0, 1'b0, 1'b0});
    step();
    check("glitch_still_idle", obs(), {4'b0000, 2'd0, 1'b0, 1'b0});

    // Withdrawal at grant cycle 3: release next edge, no timeout, ptr -> 2.
    req = 4'b0010;
    step();
    check("wd_grant", obs(), {4'b0010, 2'd1, 1'b1, 1'b0});
    step();
    step();
    check("wd_cycle3", obs(), {4'b0010, 2'd1, 1'b1, 1'b0});
    req = 4'b0000;
    step();
    check("wd_release", obs(), {4'b0000, 2'd1, 1'b0, 1'b0});
    req = 4'b0011;
    step();
    check("wd_ptr_advanced", obs(), {4'b0001, 2'd0, 1'b1, 1'b0});
    done = 1'b1;
    step();
    done = 1'b0;
    req  = 4'b0000;
    step();
    // State now: IDLE, ptr=1.

    // Hold limit: gnt lasts exactly MAXH cycles, then a one-cycle timeout.
    req = 4'b1000;
    step();
    cyc = 0;
    while (gnt == 4'b1000 && cyc < 20) begin
      cyc++;
      step();
    end
    check("hold_len", 8'(cyc), 8'(MAXH));
    check("hold_timeout", obs(), {4'b0000, 2'd3, 1'b0, 1'b1});
    step();
    check("hold_regrant", obs(), {4'b1000, 2'd3, 1'b1, 1'b0});
    done = 1'b1;
    step();
    done = 1'b0;
    check("hold_done_release", obs(), {4'b0000, 2'd3, 1'b0, 1'b0});

    // done coinciding with the limit: release, but no timeout.
    step();
    cyc = 0;
    while (gnt == 4'b1000 && cyc < 20) begin
      if (cyc == int'(MAXH) - 1) done = 1'b1;
      cyc++;
      step();
      done = 1'b0;
    end
    check("coincide_len", 8'(cyc), 8'(MAXH));
    check("coincide_no_timeout", obs(), {4'b0000, 2'd3, 1'b0, 1'b0});
    req = 4'b0000;
    step();
    check("coincide_after", obs(), {4'b0000, 2'd3, 1'b0, 1'b0});
    // State now: IDLE, ptr=0.

    // Asynchronous reset mid-grant, then arbitration restarts at id 0.
    req = 4'b0100;
    step();
    check("ar_grant", obs(), {4'b0100, 2'd2, 1'b1, 1'b0});
    req = 4'b1111;
    #3 rst_n = 1'b0;
    #1 check("ar_cleared", obs(), 8'h00);
    step();
    check("ar_held", obs(), 8'h00);
    #3 rst_n = 1'b1;
    #1;
    step();
    check("ar_restart", obs(), {4'b0001, 2'd0, 1'b1, 1'b0});
    done = 1'b1;
    step();
    done = 1'b0;
    check("ar_release", obs(), {4'b0000, 2'd0, 1'b0, 1'b0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
